// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared constants and types for the 5-stage MIPS core with
//                CP0 exceptions: exception codes, instruction-memory window,
//                exception handler entry point, IF/ID stage record.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // CP0 Cause.ExcCode values
   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Instruction memory window (inclusive) and exception entry point
   localparam logic [31:0] IM_BASE    = 32'h0000_3000;
   localparam logic [31:0] IM_LAST    = 32'h0000_4ffc;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exccode;
      logic        bd;
      logic        valid;
   } if_id_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_adel_check.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_adel_check
//  Description : Combinational instruction-fetch address check. Flags AdEL
//                when the address is not word aligned or lies outside the
//                instruction memory window [IM_BASE, IM_LAST] (unsigned).
//                Also used for the eret target check in CP0.
//  Ports       : pc   (in, 32) - address to check
//                adel (out, 1) - 1 = address error on load/fetch
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_adel_check #(
   parameter logic [31:0] IM_BASE = cpu_pkg::IM_BASE,
   parameter logic [31:0] IM_LAST = cpu_pkg::IM_LAST
) (
   input  logic [31:0] pc,
   output logic        adel
);
   // Plain unsigned magnitude compares: no +4 arithmetic, so nothing wraps.
   always_comb begin
      adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
   end

endmodule : fetch_adel_check
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : IF/ID pipeline register. Captures the fetched PC/instruction
//                pair, flags AdEL on the fetch address, tags delay-slot
//                status and handles stall, exception flush and eret kill.
//                Edge priority: reset > exc_flush > stall (en=0) >
//                eret_kill > normal load.
//  Ports       : clk, reset (sync, active-high)
//                en, exc_flush, eret_kill       - pipeline control
//                pc_f, instr_f, bd_f            - fetch stage inputs
//                pc_d, instr_d, exccode_d, bd_d, valid_d - decode outputs
//                fetch_cnt (only with IF_ID_FETCH_CNT_EN) - normal-load count
//  Options     : `define IF_ID_FETCH_CNT_EN adds the fetch_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
   parameter logic [31:0] IM_BASE    = cpu_pkg::IM_BASE,
   parameter logic [31:0] IM_LAST    = cpu_pkg::IM_LAST,
   parameter logic [31:0] HANDLER_PC = cpu_pkg::HANDLER_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        exc_flush,
   input  logic        eret_kill,
   input  logic [31:0] pc_f,
   input  logic [31:0] instr_f,
   input  logic        bd_f,
   output logic [31:0] pc_d,
   output logic [31:0] instr_d,
   output logic [4:0]  exccode_d,
   output logic        bd_d,
`ifdef IF_ID_FETCH_CNT_EN
   output logic [31:0] fetch_cnt,
`endif
   output logic        valid_d
);
   import cpu_pkg::*;

   if_id_t stage_q;
   if_id_t stage_d;
   logic   adel_f;
   logic   load_f;

   fetch_adel_check #(
      .IM_BASE (IM_BASE),
      .IM_LAST (IM_LAST)
   ) u_adel (
      .pc   (pc_f),
      .adel (adel_f)
   );

   // Next-state selection in priority order; reset is applied in the flop.
   always_comb begin
      stage_d = stage_q;
      load_f  = 1'b0;
      if (exc_flush) begin
         // Bubble carries the handler PC so EPC logic sees a sane value.
         stage_d.pc      = HANDLER_PC;
         stage_d.instr   = 32'd0;
         stage_d.exccode = EXC_NONE;
         stage_d.bd      = 1'b0;
         stage_d.valid   = 1'b0;
      end else if (!en) begin
         stage_d = stage_q;
      end else if (eret_kill) begin
         // Squash the instruction after eret but keep its PC.
         stage_d.pc      = pc_f;
         stage_d.instr   = 32'd0;
         stage_d.exccode = EXC_NONE;
         stage_d.bd      = 1'b0;
         stage_d.valid   = 1'b0;
      end else begin
         load_f          = 1'b1;
         stage_d.pc      = pc_f;
         stage_d.instr   = adel_f ? 32'd0 : instr_f;
         stage_d.exccode = adel_f ? EXC_ADEL : EXC_NONE;
         stage_d.bd      = bd_f;
         stage_d.valid   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q.pc      <= IM_BASE;
         stage_q.instr   <= 32'd0;
         stage_q.exccode <= EXC_NONE;
         stage_q.bd      <= 1'b0;
         stage_q.valid   <= 1'b0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign pc_d      = stage_q.pc;
   assign instr_d   = stage_q.instr;
   assign exccode_d = stage_q.exccode;
   assign bd_d      = stage_q.bd;
   assign valid_d   = stage_q.valid;

`ifdef IF_ID_FETCH_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] fetch_cnt_d;

   // Counts every normal load, AdEL loads included; wraps modulo 2^32.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (load_f) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`else
   // load_f only feeds the optional counter.
   logic unused_load_f;
   assign unused_load_f = load_f;
`endif

endmodule : if_id_stage
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Self-checking bench for if_id_stage: directed vector table,
//                hand-written counter sequence (IF_ID_FETCH_CNT_EN) and
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        reset, en, exc_flush, eret_kill, bd_f;
   logic [31:0] pc_f, instr_f;
   logic [31:0] pc_d, instr_d;
   logic [4:0]  exccode_d;
   logic        bd_d, valid_d;
`ifdef IF_ID_FETCH_CNT_EN
   logic [31:0] fetch_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_id_stage dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .exc_flush (exc_flush),
      .eret_kill (eret_kill),
      .pc_f      (pc_f),
      .instr_f   (instr_f),
      .bd_f      (bd_f),
      .pc_d      (pc_d),
      .instr_d   (instr_d),
      .exccode_d (exccode_d),
      .bd_d      (bd_d),
`ifdef IF_ID_FETCH_CNT_EN
      .fetch_cnt (fetch_cnt),
`endif
      .valid_d   (valid_d)
   );

   // ---------------- reference model (rules, not structure) ----------------
   logic [31:0] m_pc, m_instr, m_cnt;
   logic [4:0]  m_exc;
   logic        m_bd, m_valid;

   function automatic bit is_adel(input logic [31:0] a);
      longint unsigned u;
      u = longint'(a);
      return (u % 4 != 0) || (u < 64'h3000) || (u > 64'h4ffc);
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_cnt = 0;
      end else if (exc_flush) begin
         m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else if (!en) begin
         // hold
      end else if (eret_kill) begin
         m_pc = pc_f; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else begin
         m_pc = pc_f; m_bd = bd_f; m_valid = 1; m_cnt = m_cnt + 1;
         if (is_adel(pc_f)) begin m_exc = 4; m_instr = 0; end
         else begin m_exc = 0; m_instr = instr_f; end
      end
   endtask

   task automatic check_model(input string name);
      bit ok;
      ok = (pc_d === m_pc) && (instr_d === m_instr) && (exccode_d === m_exc) &&
           (bd_d === m_bd) && (valid_d === m_valid);
`ifdef IF_ID_FETCH_CNT_EN
      ok = ok && (fetch_cnt === m_cnt);
`endif
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got pc=%h instr=%h exc=%0d bd=%0b v=%0b, expected pc=%h instr=%h exc=%0d bd=%0b v=%0b",
                  name, pc_d, instr_d, exccode_d, bd_d, valid_d, m_pc, m_instr, m_exc, m_bd, m_valid);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic fl, input logic k,
                        input logic [31:0] p, input logic [31:0] i, input logic b);
      reset = r; en = e; exc_flush = fl; eret_kill = k; pc_f = p; instr_f = i; bd_f = b;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        r, e, fl, k;
      logic [31:0] p, i;
      logic        b;
      logic [31:0] x_pc, x_instr;
      logic [4:0]  x_exc;
      logic        x_bd, x_valid;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int exp_cnt;
      int n;
      vecs[0]  = '{1,1,0,0, 32'h0000_3000, 32'h0,          0, 32'h3000, 32'h0,          0, 0, 0};
      vecs[1]  = '{1,1,0,0, 32'h0000_3000, 32'h0,          0, 32'h3000, 32'h0,          0, 0, 0};
      vecs[2]  = '{0,1,0,0, 32'h0000_3000, 32'h3c01_1234,  0, 32'h3000, 32'h3c01_1234, 0, 0, 1};
      vecs[3]  = '{0,1,0,0, 32'h0000_3002, 32'hdead_beef,  0, 32'h3002, 32'h0,          4, 0, 1};
      vecs[4]  = '{0,1,0,0, 32'h0000_2ffc, 32'h1111_1111,  0, 32'h2ffc, 32'h0,          4, 0, 1};
      vecs[5]  = '{0,1,0,0, 32'h0000_5000, 32'h1212_1212,  0, 32'h5000, 32'h0,          4, 0, 1};
      vecs[6]  = '{0,1,0,0, 32'h0000_4ffc, 32'h2222_2222,  1, 32'h4ffc, 32'h2222_2222, 0, 1, 1};
      vecs[7]  = '{0,1,0,0, 32'hffff_fffc, 32'h3333_3333,  0, 32'hffff_fffc, 32'h0,     4, 0, 1};
      vecs[8]  = '{0,1,0,0, 32'h0000_3004, 32'h4444_4444,  0, 32'h3004, 32'h4444_4444, 0, 0, 1};
      vecs[9]  = '{0,0,0,0, 32'h0000_3008, 32'h5151_5151,  1, 32'h3004, 32'h4444_4444, 0, 0, 1};
      vecs[10] = '{0,0,0,0, 32'h0000_300c, 32'h5555_5555,  0, 32'h3004, 32'h4444_4444, 0, 0, 1};
      vecs[11] = '{0,0,0,0, 32'h0000_300c, 32'h5555_5555,  0, 32'h3004, 32'h4444_4444, 0, 0, 1};
      vecs[12] = '{0,1,0,0, 32'h0000_300c, 32'h5555_5555,  0, 32'h300c, 32'h5555_5555, 0, 0, 1};
      vecs[13] = '{0,0,1,0, 32'h0000_3010, 32'h6060_6060,  1, 32'h4180, 32'h0,          0, 0, 0};
      vecs[14] = '{0,1,0,1, 32'h0000_3020, 32'h6666_6666,  1, 32'h3020, 32'h0,          0, 0, 0};
      vecs[15] = '{0,1,0,0, 32'h0000_3024, 32'h7777_7777,  1, 32'h3024, 32'h7777_7777, 0, 1, 1};
      vecs[16] = '{0,0,0,1, 32'h0000_3028, 32'h8888_8888,  0, 32'h3024, 32'h7777_7777, 0, 1, 1};
      vecs[17] = '{0,1,1,1, 32'h0000_302c, 32'h9999_9999,  1, 32'h4180, 32'h0,          0, 0, 0};

      drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
      exp_cnt = 0;
      for (int v = 0; v < 18; v++) begin
         drive(vecs[v].r, vecs[v].e, vecs[v].fl, vecs[v].k, vecs[v].p, vecs[v].i, vecs[v].b);
         if (vecs[v].r) exp_cnt = 0;
         else if (!vecs[v].fl && vecs[v].e && !vecs[v].k) exp_cnt++;
         @(posedge clk); #1;
         checks++;
         if (pc_d !== vecs[v].x_pc || instr_d !== vecs[v].x_instr || exccode_d !== vecs[v].x_exc ||
             bd_d !== vecs[v].x_bd || valid_d !== vecs[v].x_valid) begin
            errors++;
            $display("FAIL vec%0d: got pc=%h instr=%h exc=%0d bd=%0b v=%0b, expected pc=%h instr=%h exc=%0d bd=%0b v=%0b",
                     v, pc_d, instr_d, exccode_d, bd_d, valid_d, vecs[v].x_pc, vecs[v].x_instr,
                     vecs[v].x_exc, vecs[v].x_bd, vecs[v].x_valid);
         end
`ifdef IF_ID_FETCH_CNT_EN
         checks++;
         if (fetch_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL vec%0d_cnt: got %0d expected %0d", v, fetch_cnt, exp_cnt);
         end
`endif
      end

`ifdef IF_ID_FETCH_CNT_EN
      // Counter sequence: 5 loads, 2 stalls, 1 flush, 1 kill -> 5; then reset -> 0.
      drive(1, 1, 0, 0, 32'h3000, 32'h0, 0);
      @(posedge clk); #1;
      for (int j = 0; j < 5; j++) begin
         drive(0, 1, 0, 0, 32'h3000 + 32'(j * 4), 32'h100 + 32'(j), 0);
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, 32'h3040, 32'h0, 0); @(posedge clk); #1;
      drive(0, 0, 0, 1, 32'h3044, 32'h0, 0); @(posedge clk); #1;
      drive(0, 1, 1, 0, 32'h3048, 32'h0, 0); @(posedge clk); #1;
      drive(0, 1, 0, 1, 32'h304c, 32'h0, 0); @(posedge clk); #1;
      checks++;
      if (fetch_cnt !== 32'd5) begin
         errors++;
         $display("FAIL cnt_seq: got %0d expected 5", fetch_cnt);
      end
      drive(1, 1, 0, 0, 32'h3050, 32'h0, 0); @(posedge clk); #1;
      checks++;
      if (fetch_cnt !== 32'd0) begin
         errors++;
         $display("FAIL cnt_reset: got %0d expected 0", fetch_cnt);
      end
`endif

      // ---------------- randomized traffic vs. model ----------------
      drive(1, 1, 0, 0, 32'h3000, 32'h0, 0);
      @(posedge clk); #1;
      model_edge();
      check_model("rand_reset");
      n = 0;
      for (int c = 0; c < 2000; c++) begin
         logic [31:0] p;
         case ($urandom_range(0, 5))
            0: p = 32'h3000 + (32'($urandom_range(0, 32'h7ff)) << 2);
            1: p = 32'h2ff0 + 32'($urandom_range(0, 31));
            2: p = 32'h4ff0 + 32'($urandom_range(0, 31));
            3: p = $urandom;
            4: p = 32'hffff_fff0 + 32'($urandom_range(0, 15));
            default: p = 32'h3000 + 32'($urandom_range(0, 32'h1fff));
         endcase
         drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               p, $urandom, 1'($urandom));
         #1;
         // Outputs must not follow inputs before the edge.
         check_model("no_comb_path");
         @(posedge clk); #1;
         model_edge();
         check_model("rand");
         n++;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_if_id_stage
`default_nettype wire
